// File: rtl/branch_seq_pkg.sv
// Types shared by the branch sequencer: instruction kinds, FSM states and the latched instruction payload.
`include "branch_cond_defs.svh"

package branch_seq_pkg;

    localparam int unsigned BR_XLEN = 32;
    localparam logic [BR_XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        KIND_SEQ  = 2'b00,
        KIND_BR   = 2'b01,
        KIND_JAL  = 2'b10,
        KIND_JALR = 2'b11
    } instr_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_EVAL,
        ST_OUT
    } state_e;

    typedef struct packed {
        logic [BR_XLEN-1:0] pc;
        logic [BR_XLEN-1:0] imm;
        instr_kind_e        kind;
    } instr_t;

    // The comparator only implements these conditions; anything else leaves cmp_taken stale.
    function automatic logic cond_legal(input logic [2:0] f3);
        case (f3)
            `BR_COND_BEQ, `BR_COND_BNE, `BR_COND_BLT,
            `BR_COND_BGE, `BR_COND_BLTU, `BR_COND_BGEU: cond_legal = 1'b1;
            default:                                    cond_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_defs.svh
// Shared opcode include: branch condition (funct3) encodings used by decode, the comparator and sequencers.
`ifndef BRANCH_COND_DEFS_SVH
`define BRANCH_COND_DEFS_SVH

`define BR_COND_BEQ  3'b000
`define BR_COND_BNE  3'b001
`define BR_COND_BLT  3'b100
`define BR_COND_BGE  3'b101
`define BR_COND_BLTU 3'b110
`define BR_COND_BGEU 3'b111

`endif

// File: rtl/branch_target.sv
// Combinational target adders: pc+imm, (rs1+imm)&~1 and pc+4, all modulo 2^32.
module branch_target
    import branch_seq_pkg::*;
(
    input  logic [BR_XLEN-1:0] i_pc,
    input  logic [BR_XLEN-1:0] i_imm,
    input  logic [BR_XLEN-1:0] i_rs1,
    output logic [BR_XLEN-1:0] o_pc_imm,
    output logic [BR_XLEN-1:0] o_jalr,
    output logic [BR_XLEN-1:0] o_pc_step
);

    logic [BR_XLEN-1:0] w_rs1_imm;

    assign w_rs1_imm = i_rs1 + i_imm;
    assign o_pc_imm  = i_pc + i_imm;
    assign o_jalr    = {w_rs1_imm[BR_XLEN-1:1], 1'b0};
    assign o_pc_step = i_pc + PC_STEP;

endmodule

// File: rtl/branch_sequencer.sv
// Sequences the registered branch comparator per control-transfer instruction and hands the next PC to fetch.
// Optional BRANCH_STATS_EN adds saturating resolved/taken branch counters.
`include "branch_cond_defs.svh"

module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
`ifdef BRANCH_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [1:0]      instr_kind,
    input  logic [XLEN-1:0] instr_pc,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] cmp_x,
    output logic [XLEN-1:0] cmp_y,
    output logic [2:0]      cmp_op,
    input  logic            cmp_taken,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic            flush,
    output logic [XLEN-1:0] link_addr,
    output logic            link_valid,
    output logic            misalign
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken
`endif
);

    state_e            r_state;
    instr_t            r_instr;
    logic              r_instr_ready;
    logic              r_pc_valid;
    logic              r_flush;
    logic              r_link;
    logic              r_misalign;
    logic [XLEN-1:0]   r_next_pc;
    logic [XLEN-1:0]   r_link_addr;
    logic [XLEN-1:0]   r_cmp_x;
    logic [XLEN-1:0]   r_cmp_y;
    logic [2:0]        r_cmp_op;

    instr_kind_e       w_in_kind;
    logic              w_idle;
    logic              w_accept;
    logic              w_handshake;
    logic [XLEN-1:0]   w_sel_pc;
    logic [XLEN-1:0]   w_sel_imm;
    logic [XLEN-1:0]   w_pc_imm;
    logic [XLEN-1:0]   w_jalr;
    logic [XLEN-1:0]   w_pc_step;
    logic [XLEN-1:0]   w_idle_target;
    logic              w_idle_redirect;
    logic              w_br_taken;

    assign w_in_kind   = instr_kind_e'(instr_kind);
    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = instr_valid & r_instr_ready;
    assign w_handshake = r_pc_valid & pc_ready;

    // One adder set serves both the incoming instruction (IDLE) and the latched branch (EVAL).
    assign w_sel_pc  = w_idle ? instr_pc : r_instr.pc;
    assign w_sel_imm = w_idle ? imm      : r_instr.imm;

    branch_target u_target (
        .i_pc      (w_sel_pc),
        .i_imm     (w_sel_imm),
        .i_rs1     (rs1_val),
        .o_pc_imm  (w_pc_imm),
        .o_jalr    (w_jalr),
        .o_pc_step (w_pc_step)
    );

    // Stale comparator results for unsupported conditions resolve as not-taken.
    assign w_br_taken = (r_instr.kind == KIND_BR) & cond_legal(r_cmp_op) & cmp_taken;

    always_comb begin
        w_idle_target   = w_pc_step;
        w_idle_redirect = 1'b0;
        case (w_in_kind)
            KIND_JAL: begin
                w_idle_target   = w_pc_imm;
                w_idle_redirect = 1'b1;
            end
            KIND_JALR: begin
                w_idle_target   = w_jalr;
                w_idle_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_instr_ready <= 1'b1;
            r_pc_valid    <= 1'b0;
            r_flush       <= 1'b0;
            r_link        <= 1'b0;
            r_misalign    <= 1'b0;
            r_next_pc     <= '0;
            r_link_addr   <= '0;
            r_cmp_x       <= '0;
            r_cmp_y       <= '0;
            r_cmp_op      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_instr       <= '{pc: instr_pc, imm: imm, kind: w_in_kind};
                        r_instr_ready <= 1'b0;
                        if (w_in_kind == KIND_BR) begin
                            r_cmp_x  <= rs1_val;
                            r_cmp_y  <= rs2_val;
                            r_cmp_op <= funct3;
                            r_state  <= ST_ISSUE;
                        end else begin
                            r_state     <= ST_OUT;
                            r_pc_valid  <= 1'b1;
                            r_next_pc   <= w_idle_target;
                            r_flush     <= w_idle_redirect;
                            r_link      <= w_idle_redirect;
                            r_link_addr <= w_pc_step;
                            r_misalign  <= w_idle_redirect & (|w_idle_target[1:0]);
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    r_state    <= ST_OUT;
                    r_pc_valid <= 1'b1;
                    r_next_pc  <= w_br_taken ? w_pc_imm : w_pc_step;
                    r_flush    <= w_br_taken;
                    r_link     <= 1'b0;
                    r_misalign <= w_br_taken & (|w_pc_imm[1:0]);
                end
                ST_OUT: begin
                    if (pc_ready) begin
                        r_state       <= ST_IDLE;
                        r_pc_valid    <= 1'b0;
                        r_flush       <= 1'b0;
                        r_link        <= 1'b0;
                        r_misalign    <= 1'b0;
                        r_instr_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign pc_valid    = r_pc_valid;
    assign next_pc     = r_next_pc;
    assign link_addr   = r_link_addr;
    assign cmp_x       = r_cmp_x;
    assign cmp_y       = r_cmp_y;
    assign cmp_op      = r_cmp_op;

    // Side-band pulses are qualified by the live handshake so they last exactly one accepted cycle.
    assign flush      = r_flush    & w_handshake;
    assign link_valid = r_link     & w_handshake;
    assign misalign   = r_misalign & w_handshake;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] r_stat_br;
    logic [STAT_W-1:0] r_stat_tk;
    logic              w_br_done;

    assign w_br_done = (r_state == ST_OUT) & pc_ready & (r_instr.kind == KIND_BR);

    // Saturating counters; a resolved branch flushes exactly when it was taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_br <= '0;
            r_stat_tk <= '0;
        end else if (w_br_done) begin
            if (r_stat_br != '1) r_stat_br <= r_stat_br + STAT_W'(1);
            if (r_flush && (r_stat_tk != '1)) r_stat_tk <= r_stat_tk + STAT_W'(1);
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_taken    = r_stat_tk;
`endif

endmodule
